voq_rr_scheduler: RTL and testbench

//  Per-output-port scheduler for the NUM_PORTS VOQs (one per input port) that hold buffer pointers for this output.

---
 rtl/voq_rr_scheduler_if.sv | 29 ++
 rtl/voq_rr_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_voq_rr_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voq_rr_scheduler_if.sv
// Bundle of the scheduler's VOQ-side and egress-side signals.
// master: the scheduler itself. slave: the VOQs and the egress engine that sit around it.
interface voq_rr_scheduler_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 10
);
    localparam int SRC_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        enq_i;
    logic [NUM_PORTS-1:0]        voq_read_req_o;
    logic [NUM_PORTS*ADDR_W-1:0] voq_ptr_i;
    logic [NUM_PORTS-1:0]        voq_ptr_valid_i;
    logic [ADDR_W-1:0]           egr_ptr_o;
    logic [SRC_W-1:0]            egr_src_o;
    logic                        egr_valid_o;
    logic                        egr_ready_i;
    logic                        egr_done_i;
    logic                        err_o;

    modport master (
        input  enq_i, voq_ptr_i, voq_ptr_valid_i, egr_ready_i, egr_done_i,
        output voq_read_req_o, egr_ptr_o, egr_src_o, egr_valid_o, err_o
    );

    modport slave (
        output enq_i, voq_ptr_i, voq_ptr_valid_i, egr_ready_i, egr_done_i,
        input  voq_read_req_o, egr_ptr_o, egr_src_o, egr_valid_o, err_o
    );
endinterface

// File: rtl/voq_rr_scheduler.sv
// Per-output-port round-robin scheduler over NUM_PORTS VOQs.
// Counts VOQ occupancy from enqueue pulses, grants one non-empty VOQ at a time,
// pops a single pointer from it, offers that pointer to egress and then waits
// for the packet to finish before looking for the next grant.
module voq_rr_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 10,
    parameter int VOQ_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    voq_rr_scheduler_if.master  bus
);
    localparam int CNT_W = $clog2(VOQ_DEPTH) + 1;
    localparam int SRC_W = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_PTR = 3'd2,
        OFFER    = 3'd3,
        XMIT     = 3'd4
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r [NUM_PORTS];
    logic [SRC_W-1:0]     rr_ptr_r;
    logic [SRC_W-1:0]     grant_r;
    logic [NUM_PORTS-1:0] read_req_r;
    logic [ADDR_W-1:0]    egr_ptr_r;
    logic [SRC_W-1:0]     egr_src_r;
    logic                 egr_valid_r;
    logic                 err_r;

    logic [NUM_PORTS-1:0] elig_s;
    logic [NUM_PORTS-1:0] inc_s;
    logic [SRC_W-1:0]     pick_s;
    logic                 any_s;
    logic [ADDR_W-1:0]    ptr_arr_s [NUM_PORTS];

    // Port index after p, wrapping at NUM_PORTS (which need not be a power of 2).
    function automatic logic [SRC_W-1:0] next_port(input logic [SRC_W-1:0] p);
        if (int'(p) == NUM_PORTS - 1) begin
            return '0;
        end else begin
            return p + SRC_W'(1);
        end
    endfunction

    // Single-bit read-request vector for VOQ p.
    function automatic logic [NUM_PORTS-1:0] one_hot(input logic [SRC_W-1:0] p);
        logic [NUM_PORTS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Split the flat pointer bus into one slice per VOQ.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            ptr_arr_s[k] = bus.voq_ptr_i[k*ADDR_W +: ADDR_W];
        end
    end

    // Eligibility from registered counts; enqueues into a full VOQ are dropped, so they are not counted.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            elig_s[k] = (cnt_r[k] != '0);
            inc_s[k]  = bus.enq_i[k] && (cnt_r[k] != CNT_W'(VOQ_DEPTH));
        end
    end

    // Round-robin pick: first eligible VOQ starting at rr_ptr; scanning backwards lets the lowest offset win.
    always_comb begin
        pick_s = '0;
        any_s  = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            int idx_v;
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= NUM_PORTS) begin
                idx_v = idx_v - NUM_PORTS;
            end else begin
                idx_v = idx_v;
            end
            if (elig_s[idx_v]) begin
                pick_s = SRC_W'(idx_v);
                any_s  = 1'b1;
            end else begin
                pick_s = pick_s;
                any_s  = any_s;
            end
        end
    end

    // Occupancy counters: +1 per accepted enqueue, -1 in the cycle the VOQ is read, both -> unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                case ({inc_s[k], read_req_r[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                    2'b01:   cnt_r[k] <= cnt_r[k] - CNT_W'(1);
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
        end
    end

    // Grant/issue/offer/transmit sequencer; all outputs are driven from its registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            read_req_r  <= '0;
            egr_ptr_r   <= '0;
            egr_src_r   <= '0;
            egr_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        grant_r    <= pick_s;
                        read_req_r <= one_hot(pick_s);
                        state_r    <= ISSUE;
                    end else begin
                        read_req_r <= '0;
                        state_r    <= IDLE;
                    end
                end
                ISSUE: begin
                    // The read request lives for exactly this one cycle.
                    read_req_r <= '0;
                    state_r    <= WAIT_PTR;
                end
                WAIT_PTR: begin
                    // VOQ read latency is one cycle: the pointer must be here now.
                    if (bus.voq_ptr_valid_i[grant_r]) begin
                        egr_ptr_r   <= ptr_arr_s[grant_r];
                        egr_src_r   <= grant_r;
                        egr_valid_r <= 1'b1;
                        state_r     <= OFFER;
                    end else begin
                        err_r    <= 1'b1;
                        rr_ptr_r <= next_port(grant_r);
                        state_r  <= IDLE;
                    end
                end
                OFFER: begin
                    if (bus.egr_ready_i) begin
                        egr_valid_r <= 1'b0;
                        state_r     <= XMIT;
                    end else begin
                        state_r     <= OFFER;
                    end
                end
                XMIT: begin
                    if (bus.egr_done_i) begin
                        rr_ptr_r <= next_port(grant_r);
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= XMIT;
                    end
                end
                default: begin
                    read_req_r  <= '0;
                    egr_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.voq_read_req_o = read_req_r;
    assign bus.egr_ptr_o      = egr_ptr_r;
    assign bus.egr_src_o      = egr_src_r;
    assign bus.egr_valid_o    = egr_valid_r;
    assign bus.err_o          = err_r;

endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Directed bench for voq_rr_scheduler. A small VOQ model (FIFO per port, one-cycle read
// latency) sits on the VOQ side; egress handshakes are driven by the scenario tasks.
// All stimulus and sampling happen on the falling clock edge.
module tb_voq_rr_scheduler;
    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    voq_rr_scheduler_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    voq_rr_scheduler #(.NUM_PORTS(NP), .ADDR_W(AW), .VOQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // VOQ model storage
    logic [AW-1:0] mem [NP][DEPTH];
    int            m_head [NP];
    int            m_cnt  [NP];
    logic [NP-1:0] rd_prev;
    bit            voq_broken;

    task automatic clear_model();
        for (int k = 0; k < NP; k++) begin
            m_head[k] = 0;
            m_cnt[k]  = 0;
        end
        rd_prev    = '0;
        voq_broken = 1'b0;
    endtask

    // Advance one cycle; answer last cycle's read requests; drop one-cycle pulses.
    task automatic tick();
        @(negedge clk);
        bus.enq_i           = '0;
        bus.egr_done_i      = 1'b0;
        bus.voq_ptr_valid_i = '0;
        bus.voq_ptr_i       = '0;
        for (int k = 0; k < NP; k++) begin
            if (rd_prev[k] && !voq_broken && m_cnt[k] > 0) begin
                bus.voq_ptr_i[k*AW +: AW] = mem[k][m_head[k]];
                bus.voq_ptr_valid_i[k]    = 1'b1;
                m_head[k] = (m_head[k] + 1) % DEPTH;
                m_cnt[k]  = m_cnt[k] - 1;
            end
        end
        rd_prev = bus.voq_read_req_o;
    endtask

    // Enqueue pointer p into VOQ k this cycle (a full VOQ drops it).
    task automatic push(input int k, input logic [AW-1:0] p);
        bus.enq_i[k] = 1'b1;
        if (m_cnt[k] < DEPTH) begin
            mem[k][(m_head[k] + m_cnt[k]) % DEPTH] = p;
            m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.egr_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Take one offer: wait for valid, handshake, pulse done one cycle later. Returns what was offered.
    task automatic serve(output bit ok, output int src, output logic [AW-1:0] ptr);
        wait_valid(20, ok);
        src = int'(bus.egr_src_o);
        ptr = bus.egr_ptr_o;
        if (ok) begin
            bus.egr_ready_i = 1'b1;
            tick();
            bus.egr_ready_i = 1'b0;
            bus.egr_done_i  = 1'b1;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n               = 1'b0;
        bus.enq_i           = '0;
        bus.voq_ptr_i       = '0;
        bus.voq_ptr_valid_i = '0;
        bus.egr_ready_i     = 1'b0;
        bus.egr_done_i      = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.voq_read_req_o !== 4'b0000 || bus.egr_valid_o !== 1'b0 || bus.egr_ptr_o !== 10'h000 ||
            bus.egr_src_o !== 2'd0 || bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b v=%b ptr=%h src=%0d err=%b, required all zero",
                     bus.voq_read_req_o, bus.egr_valid_o, bus.egr_ptr_o, bus.egr_src_o, bus.err_o);
        end
    endtask

    task automatic test_latency();
        logic [NP-1:0] exp_rd;
        logic          exp_v;
        do_reset();
        tick();
        push(2, 10'h05A);
        for (int c = 0; c <= 5; c++) begin
            exp_rd = (c == 2) ? 4'b0100 : 4'b0000;
            exp_v  = (c == 4) ? 1'b1 : 1'b0;
            checks++;
            if (bus.voq_read_req_o !== exp_rd || bus.egr_valid_o !== exp_v) begin
                failures++;
                $display("FAIL latency_c%0d: rd=%b valid=%b, required rd=%b valid=%b",
                         c, bus.voq_read_req_o, bus.egr_valid_o, exp_rd, exp_v);
            end
            if (c == 4) begin
                checks++;
                if (bus.egr_ptr_o !== 10'h05A || bus.egr_src_o !== 2'd2) begin
                    failures++;
                    $display("FAIL latency_data: ptr=%h src=%0d, required ptr=05a src=2",
                             bus.egr_ptr_o, bus.egr_src_o);
                end
                bus.egr_ready_i = 1'b1;
            end else begin
                bus.egr_ready_i = 1'b0;
            end
            if (c == 5) begin
                bus.egr_done_i = 1'b1;
            end
            if (c < 5) begin
                tick();
            end
        end
        bus.egr_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        bit            ok;
        int            src;
        logic [AW-1:0] ptr;
        logic [AW-1:0] exp_ptr;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            tick();
            for (int k = 0; k < NP; k++) begin
                push(k, AW'(10'h100 + k * 16 + j));
            end
        end
        for (int i = 0; i < 2 * NP; i++) begin
            serve(ok, src, ptr);
            exp_ptr = AW'(10'h100 + (i % NP) * 16 + i / NP);
            checks++;
            if (!ok || src != i % NP || ptr !== exp_ptr) begin
                failures++;
                $display("FAIL rr_order_%0d: ok=%0d src=%0d ptr=%h, required src=%0d ptr=%h",
                         i, ok, src, ptr, i % NP, exp_ptr);
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.voq_read_req_o !== 4'b0000 || bus.egr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL rr_idle_%0d: rd=%b valid=%b, required 0000 0", c, bus.voq_read_req_o, bus.egr_valid_o);
            end
        end
    endtask

    task automatic test_backpressure();
        bit            ok;
        int            src;
        logic [AW-1:0] ptr;
        do_reset();
        tick();
        push(3, 10'h3C3);
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_offer: egr_valid_o never rose, required 1");
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                push(1, 10'h111);
            end
            tick();
            checks++;
            if (bus.egr_valid_o !== 1'b1 || bus.egr_ptr_o !== 10'h3C3 || bus.egr_src_o !== 2'd3 ||
                bus.voq_read_req_o !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold_%0d: v=%b ptr=%h src=%0d rd=%b, required 1 3c3 3 0000",
                         i, bus.egr_valid_o, bus.egr_ptr_o, bus.egr_src_o, bus.voq_read_req_o);
            end
        end
        serve(ok, src, ptr);
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 1 || ptr !== 10'h111) begin
            failures++;
            $display("FAIL bp_next: ok=%0d src=%0d ptr=%h, required src=1 ptr=111", ok, src, ptr);
        end
    endtask

    task automatic test_enq_during_issue();
        bit            ok;
        bit            seen;
        int            src;
        logic [AW-1:0] ptr;
        do_reset();
        tick();
        push(1, 10'h0A1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.voq_read_req_o === 4'b0010) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL issue_seen: voq_read_req_o never 0010, required 0010");
        end
        push(1, 10'h0B2);
        tick();
        checks++;
        if (dut.cnt_r[1] !== 5'd1) begin
            failures++;
            $display("FAIL issue_cnt: cnt[1]=%0d, required 1", dut.cnt_r[1]);
        end
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 1 || ptr !== 10'h0A1) begin
            failures++;
            $display("FAIL issue_first: ok=%0d src=%0d ptr=%h, required src=1 ptr=0a1", ok, src, ptr);
        end
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 1 || ptr !== 10'h0B2) begin
            failures++;
            $display("FAIL issue_second: ok=%0d src=%0d ptr=%h, required src=1 ptr=0b2", ok, src, ptr);
        end
    endtask

    task automatic test_saturation();
        bit            ok;
        int            src;
        logic [AW-1:0] ptr;
        do_reset();
        tick();
        push(1, 10'h1F1);
        wait_valid(20, ok);
        for (int i = 0; i < 17; i++) begin
            push(0, AW'(10'h200 + i));
            tick();
        end
        checks++;
        if (dut.cnt_r[0] !== 5'd16) begin
            failures++;
            $display("FAIL sat_cnt: cnt[0]=%0d, required 16", dut.cnt_r[0]);
        end
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 1 || ptr !== 10'h1F1) begin
            failures++;
            $display("FAIL sat_blocker: ok=%0d src=%0d ptr=%h, required src=1 ptr=1f1", ok, src, ptr);
        end
        for (int i = 0; i < 16; i++) begin
            serve(ok, src, ptr);
            checks++;
            if (!ok || src != 0 || ptr !== AW'(10'h200 + i)) begin
                failures++;
                $display("FAIL sat_grant_%0d: ok=%0d src=%0d ptr=%h, required src=0 ptr=%h",
                         i, ok, src, ptr, AW'(10'h200 + i));
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.voq_read_req_o !== 4'b0000 || bus.egr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL sat_idle_%0d: rd=%b valid=%b, required 0000 0", c, bus.voq_read_req_o, bus.egr_valid_o);
            end
        end
    endtask

    task automatic test_missing_ptr();
        bit            ok;
        int            src;
        logic [AW-1:0] ptr;
        do_reset();
        voq_broken = 1'b1;
        tick();
        push(2, 10'h0E2);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (bus.err_o !== ((c == 4) ? 1'b1 : 1'b0) || bus.egr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL err_c%0d: err=%b valid=%b, required err=%0d valid=0",
                         c, bus.err_o, bus.egr_valid_o, (c == 4) ? 1 : 0);
            end
        end
        voq_broken = 1'b0;
        push(3, 10'h0E3);
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 3 || ptr !== 10'h0E3 || bus.err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_recover: ok=%0d src=%0d ptr=%h err=%b, required src=3 ptr=0e3 err=1",
                     ok, src, ptr, bus.err_o);
        end
    endtask

    task automatic test_reset_mid_offer();
        bit            ok;
        int            src;
        logic [AW-1:0] ptr;
        do_reset();
        tick();
        push(0, 10'h0AB);
        wait_valid(20, ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus.voq_read_req_o !== 4'b0000 || bus.egr_valid_o !== 1'b0 || bus.egr_ptr_o !== 10'h000 ||
            bus.egr_src_o !== 2'd0 || bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: ok=%0d rd=%b v=%b ptr=%h src=%0d err=%b, required all zero",
                     ok, bus.voq_read_req_o, bus.egr_valid_o, bus.egr_ptr_o, bus.egr_src_o, bus.err_o);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.voq_read_req_o !== 4'b0000 || bus.egr_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_%0d: rd=%b valid=%b, required 0000 0", c, bus.voq_read_req_o, bus.egr_valid_o);
            end
        end
        push(1, 10'h0CD);
        serve(ok, src, ptr);
        checks++;
        if (!ok || src != 1 || ptr !== 10'h0CD) begin
            failures++;
            $display("FAIL post_reset_serve: ok=%0d src=%0d ptr=%h, required src=1 ptr=0cd", ok, src, ptr);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_enq_during_issue();
        test_saturation();
        test_missing_ptr();
        test_reset_mid_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
